// File: rtl/vga_sprite_renderer.sv
// Pixel-colour stage for the 800x600 timing stream: background, 1-pixel white
// border and a bouncing square sprite, with syncs re-timed to match the
// two-stage colour pipeline.
module vga_sprite_renderer #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned SIZE      = 32,
  parameter int unsigned STEP      = 4,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned X0        = 0,
  parameter int unsigned Y0        = 0,
  parameter logic [15:0] BG_RGB    = 16'h001F,
  parameter logic [15:0] SP_RGB    = 16'hF800
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Ready_Sig,
  input  logic [10:0] Column_Addr_Sig,
  input  logic [9:0]  Row_Addr_Sig,
  input  logic        HSYNC_Sig,
  input  logic        VSYNC_Sig,
  input  logic        Pause_Sig,
  output logic        HSYNC_Out_Sig,
  output logic        VSYNC_Out_Sig,
  output logic [4:0]  Red_Sig,
  output logic [5:0]  Green_Sig,
  output logic [4:0]  Blue_Sig
);

  // Direction encodings: forward is right on X, down on Y.
  localparam logic DIR_FWD  = 1'b1;
  localparam logic DIR_BACK = 1'b0;

  localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  ROW_LAST = 10'(V_ACTIVE - 1);
  localparam logic [10:0] X_LIM    = 11'(H_ACTIVE - SIZE);
  localparam logic [9:0]  Y_LIM    = 10'(V_ACTIVE - SIZE);
  localparam logic [10:0] STEP_X   = 11'(STEP);
  localparam logic [9:0]  STEP_Y   = 10'(STEP);
  localparam logic [11:0] SIZE_X   = 12'(SIZE);
  localparam logic [10:0] SIZE_Y   = 11'(SIZE);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  // Stage-1 registers
  logic        ready_q;
  logic [10:0] col_q;
  logic [9:0]  row_q;
  logic        hs_q;
  logic        vs_q;

  // Sprite state
  logic [10:0] x;
  logic [9:0]  y;
  logic        dir_x;
  logic        dir_y;
  logic [7:0]  frame_cnt;

  // Stage-2 registers
  logic [15:0] rgb_q;
  logic        hs_o;
  logic        vs_o;

  logic        eof;
  logic        border;
  logic        in_sprite;
  logic [15:0] pixel_rgb;
  logic [10:0] x_next;
  logic [9:0]  y_next;
  logic        dir_x_next;
  logic        dir_y_next;

  assign eof = ready_q && (col_q == COL_LAST) && (row_q == ROW_LAST);

  assign border = (col_q == '0) || (col_q == COL_LAST) ||
                  (row_q == '0) || (row_q == ROW_LAST);

  // Widened by one bit so x+SIZE / y+SIZE cannot wrap.
  assign in_sprite = ({1'b0, col_q} >= {1'b0, x}) &&
                     ({1'b0, col_q} <  ({1'b0, x} + SIZE_X)) &&
                     ({1'b0, row_q} >= {1'b0, y}) &&
                     ({1'b0, row_q} <  ({1'b0, y} + SIZE_Y));

  // Colour priority: blanking, border, sprite, background.
  always_comb begin
    pixel_rgb = BG_RGB;
    if (!ready_q)       pixel_rgb = '0;
    else if (border)    pixel_rgb = '1;
    else if (in_sprite) pixel_rgb = SP_RGB;
  end

  // Bounce arithmetic for the next position on each axis.
  always_comb begin
    x_next     = x;
    y_next     = y;
    dir_x_next = dir_x;
    dir_y_next = dir_y;
    if (dir_x == DIR_FWD) begin
      if (({1'b0, x} + {1'b0, STEP_X}) >= {1'b0, X_LIM}) begin
        x_next     = X_LIM;
        dir_x_next = DIR_BACK;
      end else begin
        x_next = x + STEP_X;
      end
    end else begin
      if (x <= STEP_X) begin
        x_next     = '0;
        dir_x_next = DIR_FWD;
      end else begin
        x_next = x - STEP_X;
      end
    end
    if (dir_y == DIR_FWD) begin
      if (({1'b0, y} + {1'b0, STEP_Y}) >= {1'b0, Y_LIM}) begin
        y_next     = Y_LIM;
        dir_y_next = DIR_BACK;
      end else begin
        y_next = y + STEP_Y;
      end
    end else begin
      if (y <= STEP_Y) begin
        y_next     = '0;
        dir_y_next = DIR_FWD;
      end else begin
        y_next = y - STEP_Y;
      end
    end
  end

  // Stage 1: capture the incoming pixel stream.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ready_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      ready_q <= Ready_Sig;
      col_q   <= Column_Addr_Sig;
      row_q   <= Row_Addr_Sig;
      hs_q    <= HSYNC_Sig;
      vs_q    <= VSYNC_Sig;
    end
  end

  // Sprite position and frame divider, advanced only at end of frame.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      x         <= 11'(X0);
      y         <= 10'(Y0);
      dir_x     <= DIR_FWD;
      dir_y     <= DIR_FWD;
      frame_cnt <= '0;
    end else if (eof && !Pause_Sig) begin
      if (frame_cnt == DIV_LAST) begin
        frame_cnt <= '0;
        x         <= x_next;
        y         <= y_next;
        dir_x     <= dir_x_next;
        dir_y     <= dir_y_next;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Stage 2: registered colour and re-timed syncs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rgb_q <= '0;
      hs_o  <= 1'b0;
      vs_o  <= 1'b0;
    end else begin
      rgb_q <= pixel_rgb;
      hs_o  <= hs_q;
      vs_o  <= vs_q;
    end
  end

  assign {Red_Sig, Green_Sig, Blue_Sig} = rgb_q;
  assign HSYNC_Out_Sig = hs_o;
  assign VSYNC_Out_Sig = vs_o;

endmodule
